rvfpm_issue_queue: RTL and testbench
====================================

# rvfpm_issue_queue

Issue buffer that sits directly upstream of the rvfpm execution pipeline. It accepts offloaded FP instructions from the core over a valid/ready issue handshake. It holds them in a QUEUE_DEPTH-entry in-order queue until the core commits or kills them. Committed entries go to the pipeline over a valid/ready dispatch handshake; killed entries are dropped.

## Interface
Parameters:
- X_ID_WIDTH, 4, width of the instruction id
- QUEUE_DEPTH, 4, number of entries; any value ≥ 2, need not be a power of two
- XLEN, 32, width of the integer source operand carried with the instruction

Ports:
- ck  in  1  clock; all state changes on its rising edge
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  synchronous clear of all entries
- issue_valid  in  1  core offers an instruction
- issue_ready  out  1  queue accepts; equals !queue_full
- issue_instr  in  32  instruction word
- issue_id  in  X_ID_WIDTH  instruction id
- issue_rs  in  XLEN  rs1 integer operand
- commit_valid  in  1  commit/kill strobe
- commit_id  in  X_ID_WIDTH  id being resolved
- commit_kill  in  1  1 = kill, 0 = commit
- dispatch_valid  out  1  head entry is ready for the pipeline
- dispatch_ready  in  1  pipeline accepts
- dispatch_instr  out  32  head instruction word
- dispatch_id  out  X_ID_WIDTH  head id
- dispatch_rs  out  XLEN  head operand
- queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied entries
- queue_full  out  1  queue_count == QUEUE_DEPTH
- queue_empty  out  1  queue_count == 0
- queue_ids  out  QUEUE_DEPTH × X_ID_WIDTH  ids in order from head, slot 0 = head; unoccupied slots read 0 (verification visibility)

## Operation
- Circular buffer with head and tail pointers. Each pointer wraps from QUEUE_DEPTH-1 to 0.
- Entry fields: instr, id, rs, committed, killed.
- Issue handshake (issue_valid && issue_ready): write at tail with committed=0 and killed=0, then advance tail.
- Commit resolution (commit_valid): every occupied entry whose id equals commit_id gets committed=1 (kill=0) or killed=1 (kill=1).
  - It also applies to an entry being written in the same cycle when issue_id == commit_id.
  - No match: ignored, no error.
- Head states:
  - EMPTY: no entries.
  - WAIT: head uncommitted and not killed; it blocks all younger entries.
  - READY: head committed and not killed; dispatch_valid=1.
  - DROP: head killed; popped in one cycle with dispatch_valid=0.
- Dispatch handshake (dispatch_valid && dispatch_ready): pop head.
- queue_count updates each cycle by +issue −pop; 0..QUEUE_DEPTH, never wraps.
- Issue and pop in the same cycle are allowed, including when full. A full queue still shows issue_ready=0 that cycle, so the same-cycle pop does not open a slot.
- flush has priority over issue, commit and pop in the same cycle. The queue is empty the next cycle.
- dispatch_* data is valid only while dispatch_valid=1. Data is held stable while dispatch_valid=1 and dispatch_ready=0.

## Timing
- Reset values:
  - issue_ready=1, queue_empty=1
  - dispatch_valid=0, queue_full=0, queue_count=0
  - dispatch_instr/id/rs=0, queue_ids all 0
  - head and tail pointers 0
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- All outputs are driven from registered state only. There is no combinational path from any input to any output.
- Latency:
  - An instruction issued into an empty queue with a same-cycle commit gives dispatch_valid=1 on the following cycle.
  - A commit arriving later gives dispatch_valid the cycle after the commit.
- Kill at head: the entry is dropped one cycle after the kill becomes visible. The next entry can present on the cycle after that.
- Throughput: one dispatch per cycle when entries are committed and dispatch_ready=1.

## Structure
- Shared package rvfpm_pkg holds:
  - typedef rvfpm_queue_entry_t with fields instr, id, rs, committed, killed;
  - a function computing the wrapped pointer increment.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset, then issue ids 1,2,3 with no commits → queue_count=3, queue_ids={1,2,3,0}, dispatch_valid=0.
- Commit id 2, then id 1 → dispatch_valid rises the cycle after the commit of 1. With dispatch_ready=1, ids 1 then 2 dispatch on consecutive cycles. Id 3 stays queued.
- Fill to 4 entries → queue_full=1, issue_ready=0. Issue attempts are ignored and count stays 4. One pop → issue_ready=1 next cycle.
- Issue id 5 and commit id 5 in the same cycle into an empty queue → dispatch_valid=1, dispatch_id=5 on the next cycle.
- Kill head id 7 with committed id 8 behind it → 7 is never dispatched. Id 8 dispatches; queue_count goes 2→1→0.
- Wrap-around with QUEUE_DEPTH=3: 10 issue/dispatch pairs keep queue_count ≤ 3 and FIFO order intact.
- Assert rst asynchronously mid-burst → outputs return to reset values before the next edge.
- Assert flush with 3 entries plus a concurrent issue → queue_empty=1 on the next cycle.

Source files
------------

// File: rtl/rvfpm_pkg.sv
// rvfpm_pkg: shared entry type, head-state encoding and pointer helper for the rvfpm issue queue
package rvfpm_pkg;
  localparam int RVFPM_X_ID_WIDTH = 4;
  localparam int RVFPM_XLEN = 32;
  typedef struct packed {
    logic [31:0] instr;
    logic [RVFPM_X_ID_WIDTH-1:0] id;
    logic [RVFPM_XLEN-1:0] rs;
    logic committed;
    logic killed;
  } rvfpm_queue_entry_t;
  typedef enum logic [1:0] {HEAD_EMPTY, HEAD_WAIT, HEAD_READY, HEAD_DROP} rvfpm_head_state_t;
  function automatic int rvfpm_ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/rvfpm_issue_queue.sv
// rvfpm_issue_queue: in-order issue buffer holding offloaded FP instructions until commit or kill
module rvfpm_issue_queue
  import rvfpm_pkg::*;
#(
  parameter int X_ID_WIDTH = RVFPM_X_ID_WIDTH,
  parameter int QUEUE_DEPTH = 4,
  parameter int XLEN = RVFPM_XLEN,
  localparam int PW = $clog2(QUEUE_DEPTH),
  localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic ck,
  input  logic rst,
  input  logic flush,
  input  logic issue_valid,
  output logic issue_ready,
  input  logic [31:0] issue_instr,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  input  logic [XLEN-1:0] issue_rs,
  input  logic commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic commit_kill,
  output logic dispatch_valid,
  input  logic dispatch_ready,
  output logic [31:0] dispatch_instr,
  output logic [X_ID_WIDTH-1:0] dispatch_id,
  output logic [XLEN-1:0] dispatch_rs,
  output logic [CW-1:0] queue_count,
  output logic queue_full,
  output logic queue_empty,
  output logic [QUEUE_DEPTH*X_ID_WIDTH-1:0] queue_ids
);
  rvfpm_queue_entry_t q [QUEUE_DEPTH];
  rvfpm_queue_entry_t head_e;
  rvfpm_head_state_t head_st;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [QUEUE_DEPTH-1:0] hit;
  logic push, pop, new_hit;
  assign head_e = q[head];
  assign queue_count = count;
  // Classify the head entry and derive every status/dispatch output from stored state only
  always_comb begin
    head_st = (count == '0) ? HEAD_EMPTY : head_e.killed ? HEAD_DROP : head_e.committed ? HEAD_READY : HEAD_WAIT;
    queue_full = count == CW'(QUEUE_DEPTH);
    queue_empty = count == '0;
    issue_ready = !queue_full;
    dispatch_valid = head_st == HEAD_READY;
    dispatch_instr = head_e.instr;
    dispatch_id = head_e.id;
    dispatch_rs = head_e.rs;
    push = issue_valid && issue_ready;
    pop = (head_st == HEAD_READY && dispatch_ready) || head_st == HEAD_DROP;
    new_hit = commit_valid && commit_id == issue_id;
  end
  // Match the commit id against occupied slots and present ids in age order from the head
  always_comb begin
    hit = '0;
    queue_ids = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      hit[i] = commit_valid && q[i].id == commit_id && ((i - int'(head) + QUEUE_DEPTH) % QUEUE_DEPTH) < int'(count);
      if (i < int'(count)) queue_ids[i*X_ID_WIDTH +: X_ID_WIDTH] = q[(int'(head) + i) % QUEUE_DEPTH].id;
    end
  end
  // Queue storage and pointers; a same-cycle commit also resolves the entry being written at the tail
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (hit[i]) begin
          if (commit_kill) q[i].killed <= 1'b1;
          else q[i].committed <= 1'b1;
        end
      if (push) begin
        q[tail] <= '{instr: issue_instr, id: issue_id, rs: issue_rs, committed: new_hit && !commit_kill, killed: new_hit && commit_kill};
        tail <= PW'(rvfpm_ptr_inc(int'(tail), QUEUE_DEPTH));
      end
      if (pop) head <= PW'(rvfpm_ptr_inc(int'(head), QUEUE_DEPTH));
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// tb_rvfpm_issue_queue: directed and randomized checks of the issue queue against a queue-based model
module tb_rvfpm_issue_queue;
  localparam int D = 3;
  logic ck = 0, rst = 1, flush = 0;
  logic issue_valid = 0, issue_ready;
  logic [31:0] issue_instr = 0, issue_rs = 0;
  logic [3:0] issue_id = 0, commit_id = 0, dispatch_id;
  logic commit_valid = 0, commit_kill = 0, dispatch_valid, dispatch_ready = 0;
  logic [31:0] dispatch_instr, dispatch_rs;
  logic [1:0] queue_count;
  logic queue_full, queue_empty;
  logic [11:0] queue_ids;
  typedef struct {logic [31:0] instr; logic [3:0] id; logic [31:0] rs; bit c; bit k;} ent_t;
  ent_t mq[$];
  int n_chk = 0, n_pass = 0;

  always #5 ck = ~ck;

  rvfpm_issue_queue #(.X_ID_WIDTH(4), .QUEUE_DEPTH(D), .XLEN(32)) dut (
    .ck(ck), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr), .issue_id(issue_id), .issue_rs(issue_rs),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .dispatch_instr(dispatch_instr),
    .dispatch_id(dispatch_id), .dispatch_rs(dispatch_rs),
    .queue_count(queue_count), .queue_full(queue_full), .queue_empty(queue_empty), .queue_ids(queue_ids)
  );

  function automatic bit exp_dv();
    return mq.size() > 0 && mq[0].c && !mq[0].k;
  endfunction

  function automatic logic [11:0] exp_ids();
    logic [11:0] r = '0;
    foreach (mq[i]) r[i*4 +: 4] = mq[i].id;
    return r;
  endfunction

  task automatic cyc(input bit iv, input logic [3:0] iid, input bit cv, input logic [3:0] cid, input bit kill, input bit dr, input bit fl);
    ent_t e;
    bit push, pop;
    issue_valid = iv; issue_id = iid; issue_instr = $urandom; issue_rs = $urandom;
    commit_valid = cv; commit_id = cid; commit_kill = kill; dispatch_ready = dr; flush = fl;
    push = iv && mq.size() < D;
    pop = mq.size() > 0 && (mq[0].k || (mq[0].c && dr));
    if (fl) mq.delete();
    else begin
      if (cv) foreach (mq[i]) if (mq[i].id == cid) begin if (kill) mq[i].k = 1; else mq[i].c = 1; end
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.instr = issue_instr; e.id = iid; e.rs = issue_rs;
        e.c = cv && !kill && cid == iid; e.k = cv && kill && cid == iid;
        mq.push_back(e);
      end
    end
    @(posedge ck); #1;
    issue_valid = 0; commit_valid = 0; flush = 0; dispatch_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ck);
    #1 rst = 0;
    mq.delete();
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready got %b exp 1", issue_ready); else n_pass++;
    n_chk++; if (queue_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", queue_empty); else n_pass++;
    n_chk++; if (queue_full !== 1'b0 || dispatch_valid !== 1'b0) $display("FAIL reset_full_dv got %b%b exp 00", queue_full, dispatch_valid); else n_pass++;
    n_chk++; if (queue_count !== 2'd0) $display("FAIL reset_count got %0d exp 0", queue_count); else n_pass++;
    n_chk++; if ({dispatch_instr, dispatch_id, dispatch_rs, queue_ids} !== '0) $display("FAIL reset_data got %h/%h/%h/%h exp 0", dispatch_instr, dispatch_id, dispatch_rs, queue_ids); else n_pass++;
  endtask

  task automatic test_issue_no_commit();
    for (int i = 1; i <= 3; i++) cyc(1, 4'(i), 0, 0, 0, 0, 0);
    n_chk++; if (queue_count !== 2'd3) $display("FAIL issue_count got %0d exp 3", queue_count); else n_pass++;
    n_chk++; if (queue_ids !== 12'h321) $display("FAIL issue_ids got %h exp 321", queue_ids); else n_pass++;
    n_chk++; if (dispatch_valid !== 1'b0) $display("FAIL issue_dv got %b exp 0", dispatch_valid); else n_pass++;
    n_chk++; if (queue_full !== 1'b1 || issue_ready !== 1'b0) $display("FAIL issue_full got full=%b ready=%b exp 1/0", queue_full, issue_ready); else n_pass++;
  endtask

  task automatic test_commit_order();
    logic [31:0] ins, rs;
    cyc(0, 0, 1, 2, 0, 0, 0);
    n_chk++; if (dispatch_valid !== 1'b0) $display("FAIL commit2_dv got %b exp 0", dispatch_valid); else n_pass++;
    ins = mq[0].instr; rs = mq[0].rs;
    cyc(0, 0, 1, 1, 0, 0, 0);
    n_chk++; if (dispatch_valid !== 1'b1 || dispatch_id !== 4'd1) $display("FAIL commit1_head got dv=%b id=%0d exp 1/1", dispatch_valid, dispatch_id); else n_pass++;
    n_chk++; if (dispatch_instr !== ins || dispatch_rs !== rs) $display("FAIL commit1_data got %h/%h exp %h/%h", dispatch_instr, dispatch_rs, ins, rs); else n_pass++;
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (dispatch_valid !== 1'b1 || dispatch_instr !== ins) $display("FAIL stall_hold got dv=%b instr=%h exp 1/%h", dispatch_valid, dispatch_instr, ins); else n_pass++;
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_chk++; if (dispatch_valid !== 1'b1 || dispatch_id !== 4'd2) $display("FAIL b2b_second got dv=%b id=%0d exp 1/2", dispatch_valid, dispatch_id); else n_pass++;
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_chk++; if (dispatch_valid !== 1'b0 || queue_count !== 2'd1 || queue_ids !== 12'h003) $display("FAIL after_b2b got dv=%b cnt=%0d ids=%h exp 0/1/003", dispatch_valid, queue_count, queue_ids); else n_pass++;
  endtask

  task automatic test_full();
    cyc(1, 4, 0, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0);
    n_chk++; if (queue_full !== 1'b1 || issue_ready !== 1'b0) $display("FAIL full_flags got full=%b ready=%b exp 1/0", queue_full, issue_ready); else n_pass++;
    cyc(1, 6, 0, 0, 0, 0, 0);
    n_chk++; if (queue_count !== 2'd3 || queue_ids !== 12'h543) $display("FAIL full_ignore got cnt=%0d ids=%h exp 3/543", queue_count, queue_ids); else n_pass++;
    cyc(0, 0, 1, 3, 0, 0, 0);
    cyc(1, 9, 0, 0, 0, 1, 0);
    n_chk++; if (queue_count !== 2'd2 || issue_ready !== 1'b1 || queue_ids !== 12'h054) $display("FAIL full_pop got cnt=%0d ready=%b ids=%h exp 2/1/054", queue_count, issue_ready, queue_ids); else n_pass++;
  endtask

  task automatic test_flush();
    cyc(1, 6, 0, 0, 0, 0, 0);
    cyc(1, 7, 1, 6, 0, 1, 1);
    n_chk++; if (queue_empty !== 1'b1 || queue_count !== 2'd0 || queue_ids !== '0) $display("FAIL flush_full got empty=%b cnt=%0d ids=%h exp 1/0/0", queue_empty, queue_count, queue_ids); else n_pass++;
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 2, 1, 2, 0, 0, 1);
    n_chk++; if (queue_empty !== 1'b1 || dispatch_valid !== 1'b0) $display("FAIL flush_issue got empty=%b dv=%b exp 1/0", queue_empty, dispatch_valid); else n_pass++;
  endtask

  task automatic test_same_cycle();
    cyc(1, 5, 1, 5, 0, 0, 0);
    n_chk++; if (dispatch_valid !== 1'b1 || dispatch_id !== 4'd5) $display("FAIL same_cycle got dv=%b id=%0d exp 1/5", dispatch_valid, dispatch_id); else n_pass++;
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_chk++; if (queue_empty !== 1'b1) $display("FAIL same_cycle_pop got empty=%b exp 1", queue_empty); else n_pass++;
  endtask

  task automatic test_kill();
    cyc(1, 7, 0, 0, 0, 0, 0);
    cyc(1, 8, 1, 8, 0, 0, 0);
    cyc(0, 0, 1, 7, 1, 1, 0);
    n_chk++; if (queue_count !== 2'd2 || dispatch_valid !== 1'b0) $display("FAIL kill_visible got cnt=%0d dv=%b exp 2/0", queue_count, dispatch_valid); else n_pass++;
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_chk++; if (queue_count !== 2'd1 || dispatch_valid !== 1'b1 || dispatch_id !== 4'd8) $display("FAIL kill_drop got cnt=%0d dv=%b id=%0d exp 1/1/8", queue_count, dispatch_valid, dispatch_id); else n_pass++;
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_chk++; if (queue_count !== 2'd0 || dispatch_valid !== 1'b0) $display("FAIL kill_drain got cnt=%0d dv=%b exp 0/0", queue_count, dispatch_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 4'(i), 1, 4'(i), 0, 1, 0);
      n_chk++;
      if (queue_count > 2'd3 || queue_count !== 2'(mq.size()) || dispatch_valid !== exp_dv() || (exp_dv() && dispatch_id !== mq[0].id))
        $display("FAIL wrap_%0d got cnt=%0d dv=%b id=%0d exp %0d/%b/%0d", i, queue_count, dispatch_valid, dispatch_id, mq.size(), exp_dv(), i);
      else n_pass++;
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0);
    rst = 1;
    #2;
    n_chk++; if (queue_count !== 2'd0 || queue_empty !== 1'b1 || issue_ready !== 1'b1 || dispatch_valid !== 1'b0) $display("FAIL async_rst_flags got cnt=%0d empty=%b ready=%b dv=%b exp 0/1/1/0", queue_count, queue_empty, issue_ready, dispatch_valid); else n_pass++;
    n_chk++; if ({dispatch_instr, dispatch_id, dispatch_rs, queue_ids} !== '0) $display("FAIL async_rst_data got %h/%h/%h/%h exp 0", dispatch_instr, dispatch_id, dispatch_rs, queue_ids); else n_pass++;
    #1 rst = 0;
    mq.delete();
    @(posedge ck); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), $urandom_range(0, 2) != 0, 4'($urandom_range(0, 7)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
      n_chk++;
      if (queue_count !== 2'(mq.size()) || dispatch_valid !== exp_dv() || queue_ids !== exp_ids() ||
          issue_ready !== (mq.size() < D) || queue_full !== (mq.size() == D) || queue_empty !== (mq.size() == 0) ||
          (exp_dv() && {dispatch_instr, dispatch_id, dispatch_rs} !== {mq[0].instr, mq[0].id, mq[0].rs}))
        $display("FAIL random_%0d got cnt=%0d dv=%b ids=%h id=%0d exp cnt=%0d dv=%b ids=%h", n, queue_count, dispatch_valid, queue_ids, dispatch_id, mq.size(), exp_dv(), exp_ids());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_issue_no_commit();
    test_commit_order();
    test_full();
    test_flush();
    test_same_cycle();
    test_kill();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
